// File: rtl/strip_seq_pkg.sv
// Shared types and helpers for the strip/window address sequencer.
package strip_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IO       = 3'd1,
    ST_STEP     = 3'd2,
    ST_WAIT_STG = 3'd3,
    ST_ADVANCE  = 3'd4,
    ST_DONE     = 3'd5
  } strip_state_t;

  // Bits needed to hold a full read window (strip plus halo on both sides).
  function automatic int unsigned win_len_w(input int unsigned out_w,
                                            input int unsigned margin);
    return $clog2(out_w + 2 * margin + 1);
  endfunction

endpackage

// File: rtl/strip_window_calc.sv
// Combinational read/write window math for one anchor position.
module strip_window_calc
  import strip_seq_pkg::*;
#(
  parameter int unsigned OUT_W  = 10,
  parameter int unsigned MARGIN = 5,
  parameter int unsigned LAG    = 4,
  parameter int unsigned DIM_W  = 16,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = win_len_w(OUT_W, MARGIN)
) (
  input  logic [DIM_W-1:0]  anchor_x,
  input  logic [DIM_W-1:0]  anchor_y,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LEN_W-1:0]  wr_len
);

  localparam int unsigned XW = DIM_W + 1;

  logic [XW-1:0]    ax, ay, w, h;
  logic [XW-1:0]    rd_x, rd_span, rd_room, rd_fit;
  logic [XW-1:0]    wr_room, wr_fit;
  logic [DIM_W-1:0] wr_row;

  // One extra bit keeps W-rd_x and anchor_x+OUT_W from wrapping.
  always_comb begin
    ax      = {1'b0, anchor_x};
    ay      = {1'b0, anchor_y};
    w       = {1'b0, width};
    h       = {1'b0, height};
    rd_x    = (ax >= XW'(MARGIN)) ? (ax - XW'(MARGIN)) : '0;
    rd_span = ax + XW'(OUT_W + MARGIN) - rd_x;
    rd_room = w - rd_x;
    rd_fit  = (rd_span < rd_room) ? rd_span : rd_room;
    rd_len  = (ay < h) ? LEN_W'(rd_fit) : '0;

    wr_row  = anchor_y - DIM_W'(LAG);
    wr_room = w - ax;
    wr_fit  = (wr_room < XW'(OUT_W)) ? wr_room : XW'(OUT_W);
    wr_len  = ((ay >= XW'(LAG)) && ({1'b0, wr_row} < h)) ? LEN_W'(wr_fit) : '0;

    rd_addr = in_base + ADDR_W'(width) * ADDR_W'(anchor_y) + ADDR_W'(rd_x);
    wr_addr = out_base + ADDR_W'(width) * ADDR_W'(wr_row) + ADDR_W'(anchor_x);
  end

endmodule

// File: rtl/strip_window_sequencer.sv
// Strip-by-strip anchor sequencer: issues read/write windows, pulses the
// pipeline and waits for every filter stage to report final.
module strip_window_sequencer
  import strip_seq_pkg::*;
#(
  parameter int unsigned OUT_W      = 10,
  parameter int unsigned MARGIN     = 5,
  parameter int unsigned LAG        = 4,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned DIM_W      = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LEN_W      = win_len_w(OUT_W, MARGIN)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIM_W-1:0]      width,
  input  logic [DIM_W-1:0]      height,
  input  logic [ADDR_W-1:0]     in_base,
  input  logic [ADDR_W-1:0]     out_base,
  output logic                  io_req,
  input  logic                  io_done,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [LEN_W-1:0]      rd_len,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [LEN_W-1:0]      wr_len,
  output logic [DIM_W-1:0]      anchor_x,
  output logic [DIM_W-1:0]      anchor_y,
  output logic                  anchor_moving,
  input  logic [NUM_STAGES-1:0] stage_final,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned XW = DIM_W + 1;

  strip_state_t      state;
  logic [DIM_W-1:0]  w_q, h_q;
  logic [ADDR_W-1:0] in_base_q, out_base_q;

  logic [DIM_W-1:0]  calc_ax, calc_ay, calc_w, calc_h;
  logic [ADDR_W-1:0] calc_in_base, calc_out_base;
  logic [ADDR_W-1:0] calc_rd_addr, calc_wr_addr;
  logic [LEN_W-1:0]  calc_rd_len, calc_wr_len;
  logic [XW-1:0]     next_strip_x;
  logic              last_row, no_xfer;

  // Window is computed from the anchor about to be entered, so the
  // registered window is already valid in the first IO cycle.
  always_comb begin
    next_strip_x = {1'b0, anchor_x} + XW'(OUT_W);
    last_row     = ({1'b0, anchor_y} == ({1'b0, h_q} + XW'(LAG - 1)));
    if (state == ST_IDLE) begin
      calc_ax       = '0;
      calc_ay       = '0;
      calc_w        = width;
      calc_h        = height;
      calc_in_base  = in_base;
      calc_out_base = out_base;
    end else begin
      calc_ax       = last_row ? next_strip_x[DIM_W-1:0] : anchor_x;
      calc_ay       = last_row ? '0 : (anchor_y + DIM_W'(1));
      calc_w        = w_q;
      calc_h        = h_q;
      calc_in_base  = in_base_q;
      calc_out_base = out_base_q;
    end
  end

  strip_window_calc #(
    .OUT_W (OUT_W),
    .MARGIN(MARGIN),
    .LAG   (LAG),
    .DIM_W (DIM_W),
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_calc (
    .anchor_x(calc_ax),
    .anchor_y(calc_ay),
    .width   (calc_w),
    .height  (calc_h),
    .in_base (calc_in_base),
    .out_base(calc_out_base),
    .rd_addr (calc_rd_addr),
    .rd_len  (calc_rd_len),
    .wr_addr (calc_wr_addr),
    .wr_len  (calc_wr_len)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      anchor_x   <= '0;
      anchor_y   <= '0;
      rd_addr    <= '0;
      rd_len     <= '0;
      wr_addr    <= '0;
      wr_len     <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            w_q        <= width;
            h_q        <= height;
            in_base_q  <= in_base;
            out_base_q <= out_base;
            anchor_x   <= '0;
            anchor_y   <= '0;
            if ((width == '0) || (height == '0)) begin
              state <= ST_DONE;
            end else begin
              rd_addr <= calc_rd_addr;
              rd_len  <= calc_rd_len;
              wr_addr <= calc_wr_addr;
              wr_len  <= calc_wr_len;
              state   <= ST_IO;
            end
          end
        end
        ST_IO: begin
          if (no_xfer || io_done) state <= ST_STEP;
        end
        ST_STEP: state <= ST_WAIT_STG;
        ST_WAIT_STG: begin
          if (&stage_final) state <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          anchor_x <= calc_ax;
          anchor_y <= calc_ay;
          if (last_row && (next_strip_x >= {1'b0, w_q})) begin
            state <= ST_DONE;
          end else begin
            rd_addr <= calc_rd_addr;
            rd_len  <= calc_rd_len;
            wr_addr <= calc_wr_addr;
            wr_len  <= calc_wr_len;
            state   <= ST_IO;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    no_xfer       = (rd_len == '0) && (wr_len == '0);
    io_req        = (state == ST_IO) && !no_xfer;
    anchor_moving = (state == ST_STEP);
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
  end

endmodule

// File: tb/tb_strip_window_sequencer.sv
// Directed bench for strip_window_sequencer with hand-computed windows.
module tb_strip_window_sequencer;

  localparam int unsigned OUT_W = 10, MARGIN = 5, LAG = 4, NUM_STAGES = 4;
  localparam int unsigned DIM_W = 16, ADDR_W = 32, LEN_W = 5;

  logic                  clk = 1'b0;
  logic                  n_rst, start, abort, io_done;
  logic [DIM_W-1:0]      width, height;
  logic [ADDR_W-1:0]     in_base, out_base;
  logic                  io_req, anchor_moving, busy, done;
  logic [ADDR_W-1:0]     rd_addr, wr_addr;
  logic [LEN_W-1:0]      rd_len, wr_len;
  logic [DIM_W-1:0]      anchor_x, anchor_y;
  logic [NUM_STAGES-1:0] stage_final;

  int n_cmp = 0, n_bad = 0;
  int pulse_cnt = 0, done_cnt = 0, dbl_pulse = 0, req_total = 0;
  int req_run = 0, last_req_run = 0, io_delay = 1, req_cycles = 0;
  int cyc = 0, hold_left = 0;
  logic hold_stage = 1'b0, io_seen = 1'b0, prev_am = 1'b0;

  logic [DIM_W-1:0]  p_ax [64];
  logic [DIM_W-1:0]  p_ay [64];
  logic [LEN_W-1:0]  p_rdl[64];
  logic [LEN_W-1:0]  p_wrl[64];
  logic [ADDR_W-1:0] p_rda[64];
  logic [ADDR_W-1:0] p_wra[64];
  logic              p_io [64];
  int                p_cyc[64];

  strip_window_sequencer #(
    .OUT_W(OUT_W), .MARGIN(MARGIN), .LAG(LAG), .NUM_STAGES(NUM_STAGES),
    .DIM_W(DIM_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .width(width), .height(height), .in_base(in_base), .out_base(out_base),
    .io_req(io_req), .io_done(io_done), .rd_addr(rd_addr), .rd_len(rd_len),
    .wr_addr(wr_addr), .wr_len(wr_len), .anchor_x(anchor_x), .anchor_y(anchor_y),
    .anchor_moving(anchor_moving), .stage_final(stage_final), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: records the window seen at each anchor_moving pulse.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) stage_final = '1;
      end
      if (anchor_moving) begin
        if (prev_am) dbl_pulse++;
        if (pulse_cnt < 64) begin
          p_ax[pulse_cnt]  = anchor_x;  p_ay[pulse_cnt]  = anchor_y;
          p_rdl[pulse_cnt] = rd_len;    p_wrl[pulse_cnt] = wr_len;
          p_rda[pulse_cnt] = rd_addr;   p_wra[pulse_cnt] = wr_addr;
          p_io[pulse_cnt]  = io_seen;   p_cyc[pulse_cnt] = cyc;
        end
        pulse_cnt++;
        io_seen = 1'b0;
        if (hold_stage) begin
          stage_final = 4'b1011;
          hold_left   = 7;
          hold_stage  = 1'b0;
        end
      end
      prev_am = anchor_moving;
      if (io_req) begin
        io_seen = 1'b1;
        req_total++;
        req_run++;
      end else if (req_run != 0) begin
        last_req_run = req_run;
        req_run = 0;
      end
      if (done) done_cnt++;
    end
  end

  // I/O engine model: answers io_req after io_delay cycles.
  initial begin
    io_done = 1'b0;
    forever begin
      @(negedge clk);
      if (io_done) begin
        io_done = 1'b0;
        req_cycles = 0;
      end else if (io_req) begin
        req_cycles++;
        if (req_cycles >= io_delay) io_done = 1'b1;
      end else begin
        req_cycles = 0;
      end
    end
  end

  task automatic begin_frame(input logic [DIM_W-1:0] w, input logic [DIM_W-1:0] h);
    @(negedge clk);
    width = w; height = h;
    in_base = 32'h1000; out_base = 32'h2000;
    pulse_cnt = 0; done_cnt = 0; req_total = 0; io_seen = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) chk({tag, "_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; abort = 1'b0;
    width = '0; height = '0; in_base = '0; out_base = '0;
    stage_final = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_io_req", io_req, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_len", rd_len, 0);
    chk("rst_anchor_y", anchor_y, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Frame 1: W=25 H=3, fast I/O, stages always final.
    io_delay = 1;
    begin_frame(16'd25, 16'd3);
    wait_done("f1");
    chk("f1_pulses", pulse_cnt, 21);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_double_pulse", dbl_pulse, 0);
    chk("f1_busy_after", busy, 1'b0);
    chk("p0_ax", p_ax[0], 0);
    chk("p0_ay", p_ay[0], 0);
    chk("p0_rd_len", p_rdl[0], 15);
    chk("p0_rd_addr", p_rda[0], 32'h1000);
    chk("p0_wr_len", p_wrl[0], 0);
    chk("p0_io", p_io[0], 1'b1);
    chk("p2_rd_len", p_rdl[2], 15);
    chk("p3_rd_len", p_rdl[3], 0);
    chk("p3_wr_len", p_wrl[3], 0);
    chk("p3_no_io", p_io[3], 1'b0);
    chk("p4_wr_len", p_wrl[4], 10);
    chk("p4_wr_addr", p_wra[4], 32'h2000);
    chk("p4_rd_len", p_rdl[4], 0);
    chk("p7_ax", p_ax[7], 10);
    chk("p7_ay", p_ay[7], 0);
    chk("p7_rd_len", p_rdl[7], 20);
    chk("p7_rd_addr", p_rda[7], 32'h1005);
    chk("p9_rd_addr", p_rda[9], 32'h1037);
    chk("p13_ay", p_ay[13], 6);
    chk("p13_wr_addr", p_wra[13], 32'h203C);
    chk("p13_wr_len", p_wrl[13], 10);
    chk("p14_ax", p_ax[14], 20);
    chk("p14_rd_len", p_rdl[14], 10);
    chk("p14_rd_addr", p_rda[14], 32'h100F);
    chk("p18_wr_len", p_wrl[18], 5);
    chk("p18_wr_addr", p_wra[18], 32'h2014);
    chk("p20_ay", p_ay[20], 6);

    // Frame 2: slow I/O and one stage late after the first pulse.
    io_delay = 5;
    hold_stage = 1'b1;
    begin_frame(16'd25, 16'd3);
    wait_done("f2");
    chk("f2_pulses", pulse_cnt, 21);
    chk("f2_stall_gap", p_cyc[1] - p_cyc[0], 14);
    chk("f2_req_cycles", last_req_run, 5);
    chk("f2_p1_ay", p_ay[1], 1);

    // Zero width: straight to done, no transfers.
    io_delay = 1;
    begin_frame(16'd0, 16'd3);
    @(posedge clk);
    chk("w0_done", done_cnt, 1);
    repeat (3) @(negedge clk);
    chk("w0_done_once", done_cnt, 1);
    chk("w0_no_req", req_total, 0);
    chk("w0_no_pulse", pulse_cnt, 0);

    // Abort while waiting on stages.
    stage_final = 4'b0111;
    begin_frame(16'd25, 16'd3);
    begin
      int n;
      n = 0;
      while (pulse_cnt == 0 && n < 200) begin
        @(posedge clk);
        n++;
      end
      chk("ab_pulse_seen", pulse_cnt, 1);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("ab_busy", busy, 1'b0);
    chk("ab_io_req", io_req, 1'b0);
    chk("ab_am", anchor_moving, 1'b0);
    repeat (5) @(negedge clk);
    chk("ab_no_done", done_cnt, 0);
    stage_final = '1;
    begin_frame(16'd25, 16'd3);
    wait_done("f3");
    chk("f3_pulses", pulse_cnt, 21);
    chk("f3_p0_ax", p_ax[0], 0);
    chk("f3_p0_ay", p_ay[0], 0);
    chk("f3_p0_rd_len", p_rdl[0], 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/strip_window_sequencer.md
Name: strip_window_sequencer

Overview:
Parametrised successor to the edge-detect top-level address/anchor logic. Traverses the image in vertical strips OUT_W pixels wide and steps one row at a time. For each step it issues a read window (strip plus MARGIN pixels of halo each side) and a delayed write window (LAG rows behind), then pulses anchor_moving and waits for all NUM_STAGES filter stages to report final. It sits between the memory I/O engine and the blur/gradient/nms/hyst pipeline, and replaces the fixed 15/20/10 block sizes and fixed Y_OFFSET.

Parameters:
OUT_W, 10, output pixels written per step (strip width)
MARGIN, 5, halo pixels read on each side of the strip
LAG, 4, pipeline latency in rows between read row and write row
NUM_STAGES, 4, number of stage_final inputs AND-reduced
DIM_W, 16, width/height/coordinate width
ADDR_W, 32, address width
LEN_W, $clog2(OUT_W+2*MARGIN+1), length field width

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
start  in  1  begin frame (sampled in IDLE only)
abort  in  1  synchronous return to IDLE
width  in  DIM_W  image width W (latched at start)
height  in  DIM_W  image height H (latched at start)
in_base  in  ADDR_W  input frame base (latched)
out_base  in  ADDR_W  output frame base (latched)
io_req  out  1  transfer request, held until io_done
io_done  in  1  I/O engine completed current rd+wr transfers
rd_addr  out  ADDR_W  read window start address
rd_len  out  LEN_W  read pixels (0 = no read)
wr_addr  out  ADDR_W  write window start address
wr_len  out  LEN_W  write pixels (0 = no write)
anchor_x  out  DIM_W  strip output x (strip*OUT_W)
anchor_y  out  DIM_W  step row, 0..H+LAG-1
anchor_moving  out  1  one-cycle pulse: pipeline advance
stage_final  in  NUM_STAGES  per-stage completion flags
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: state IDLE; all outputs 0; latched W/H/bases 0.
- States: IDLE, IO, STEP, WAIT_STG, ADVANCE, DONE.
- IDLE: on start, latch inputs and set anchor_x=0, anchor_y=0. Go to DONE if W==0 or H==0, else IO.
- Window math, registered and stable from entry to IO until ADVANCE:
  - rd_x = max(anchor_x-MARGIN, 0).
  - rd_len = (anchor_y<H) ? min(anchor_x+OUT_W+MARGIN-rd_x, W-rd_x) : 0.
  - wr_row = anchor_y-LAG.
  - wr_len = (anchor_y>=LAG && wr_row<H) ? min(OUT_W, W-anchor_x) : 0.
  - rd_addr = in_base + W*anchor_y + rd_x.
  - wr_addr = out_base + W*wr_row + anchor_x.
  - Addresses computed mod 2^ADDR_W. Addresses with zero length are don't-care but must be driven deterministically.
- IO:
  - If rd_len==0 and wr_len==0: io_req stays 0; go to STEP after 1 cycle.
  - Otherwise io_req=1 until io_done is sampled high; io_req drops in the next cycle and the FSM goes to STEP.
  - io_done outside IO is ignored.
- STEP: anchor_moving=1 for exactly one cycle; go to WAIT_STG.
- WAIT_STG: stage_final is first sampled the cycle after the pulse. Stay until &stage_final==1.
- ADVANCE:
  - If anchor_y==H+LAG-1: anchor_y=0, anchor_x+=OUT_W. Go to DONE if the new anchor_x>=W, else IO.
  - Otherwise anchor_y++ and go to IO.
- DONE: done=1 for one cycle, then IDLE.
- Totals: ceil(W/OUT_W) strips × (H+LAG) steps.
- abort: any state goes to IDLE next cycle. io_req and anchor_moving are low next cycle; no done pulse. abort beats start when both are asserted in the same cycle.
- start while busy: ignored.
- Coordinate compare/add uses DIM_W+1 bits so that W-rd_x and anchor_x+OUT_W cannot wrap.

Decomposition:
- Package strip_seq_pkg: state enum, and a LEN_W-derived length function (clog2 helper).
- One sub-module, strip_window_calc (combinational window math, registered by the parent). Lets the verification engineer check window equations standalone.

Test Plan:
1. W=25,H=3, OUT_W=10, MARGIN=5, LAG=4, in_base=0x1000, out_base=0x2000, stage_final tied high, io_done 1 cycle after io_req -> 21 anchor_moving pulses, then 1 done pulse; strip anchor_x 0/10/20.
2. Same config, read window lengths -> strip0 rd_len=15 (rd_x 0), strip1 rd_len=20, rd_addr at y=2 equals 0x1037, strip2 rd_len=10 (rd_x 15).
3. Same config, write window -> strip1 y=6 gives wr_addr=0x203C, wr_len=10; strip2 wr_len=5; wr_len=0 for y<4.
4. Same config, y=3 step (rd_len=0, wr_len=0) -> no io_req, anchor_moving still pulses.
5. stage_final[2] held low 7 cycles after a pulse; io_done delayed 5 cycles -> no ADVANCE until all stage_final bits are high; io_req held 5 cycles then dropped.
6. W=0 start -> done pulse 2 cycles later with no io_req. abort mid-WAIT_STG -> IDLE next cycle with no done, and a subsequent start restarts at (0,0).
